// File: rtl/fc_pkg.sv
// Shared defaults and state encoding for the fully-connected activation loader.
package fc_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned IN_DEF    = 128;
    localparam int unsigned ZW_DEF    = WIDTH_DEF * 2 + $clog2(IN_DEF);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SETTLE = 2'd1,
        S_OUT    = 2'd2
    } state_e;

endpackage

// File: rtl/fc_act_loader.sv
// Collects a streamed activation vector, holds it on the layer input while the
// combinational layer settles, then registers the layer result for handoff.
module fc_act_loader
    import fc_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned IN     = IN_DEF,
    parameter int unsigned SETTLE = 2,
    localparam int unsigned ZW    = WIDTH * 2 + $clog2(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [WIDTH-1:0] x_vec [0:IN-1],
    input  logic [ZW-1:0]    z_in,
    output logic [ZW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err
);

    localparam int unsigned IDXW = $clog2(IN);
    localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(IN - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_vec_q [0:IN-1];
    logic [WIDTH-1:0] x_vec_d [0:IN-1];
    logic [ZW-1:0]    m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             s_ready_q, s_ready_d;

    // Next-state, datapath and output computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        x_vec_d     = x_vec_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_FILL: begin
                if (s_valid) begin
                    x_vec_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        state_d     = S_SETTLE;
                        cnt_d       = CW'(SETTLE - 1);
                        idx_d       = '0;
                        frame_err_d = ~s_last;
                    end else if (s_last) begin
                        // Short vector: discard it and restart at element 0
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    m_data_d  = z_in;
                    m_valid_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        s_ready_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            idx_q       <= '0;
            cnt_q       <= '0;
            x_vec_q     <= '{default: '0};
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            s_ready_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            x_vec_q     <= x_vec_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            s_ready_q   <= s_ready_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign x_vec     = x_vec_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader with a stand-in layer: z = relu(sum w[i]*x[i] - 100),
// w[i] = 1 for i < 64 and 2 otherwise.
module tb_fc_act_loader;
    import fc_pkg::*;

    localparam int unsigned WIDTH = WIDTH_DEF;
    localparam int unsigned IN    = IN_DEF;
    localparam int unsigned ZW    = ZW_DEF;

    // Hand-computed layer results for the directed vectors
    localparam logic [31:0] Z_RAMP = 32'd14140;   // x[i]=i: 2016 + 2*6112 - 100
    localparam logic [31:0] Z_ONES = 32'd48860;   // x[i]=0xFF: 192*255 - 100
    localparam logic [31:0] Z_ZERO = 32'd0;       // x[i]=0: relu(-100)

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic [WIDTH-1:0] x_vec [0:IN-1];
    logic [ZW-1:0]    z_in;
    logic [ZW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt = 0;
    int layer_acc;

    always #5 clk = ~clk;

    fc_act_loader #(.WIDTH(WIDTH), .IN(IN), .SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .x_vec     (x_vec),
        .z_in      (z_in),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err)
    );

    always_comb begin
        layer_acc = -100;
        for (int i = 0; i < int'(IN); i++)
            layer_acc = layer_acc + ((i < 64) ? 1 : 2) * int'(x_vec[i]);
        z_in = (layer_acc < 0) ? '0 : ZW'(layer_acc);
    end

    always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // mode 0: x=i, 1: 0xFF, 2: 0x00; last_at < 0 means no s_last
    task automatic send_vec(input int n, input int mode, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            while (gaps && ($urandom_range(1, 0) == 1)) begin
                s_valid = 1'b0;
                s_data  = 8'hAA;
                s_last  = 1'b1;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = (mode == 0) ? WIDTH'(i) : (mode == 1) ? 8'hFF : 8'h00;
            s_last  = (i == last_at);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called just after the last beat's edge N: m_valid must rise at edge N+2
    task automatic check_result(input string tag, input logic [31:0] exp, input logic exp_ferr);
        @(negedge clk);
        check({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
        check({tag, "_vld_n0"}, 32'(m_valid), 32'd0);
        check({tag, "_rdy_settle"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        check({tag, "_vld_n1"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld_n2"}, 32'(m_valid), 32'd1);
        check({tag, "_data"}, 32'(m_data), exp);
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check({tag, "_drain_vld"}, 32'(m_valid), 32'd0);
        check({tag, "_drain_rdy"}, 32'(s_ready), 32'd1);
    endtask

    task automatic check_x_zero(input string tag);
        int nz = 0;
        for (int i = 0; i < int'(IN); i++) if (x_vec[i] !== '0) nz++;
        check(tag, 32'(nz), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check_x_zero("rst_xvec");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Nominal ramp vector
        send_vec(IN, 0, IN - 1, 1'b0);
        check_result("nom", Z_RAMP, 1'b0);

        // Backpressure: output must hold while m_ready is low
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_vld", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), Z_RAMP);
            check("bp_rdy", 32'(s_ready), 32'd0);
        end
        @(posedge clk); #1;
        drain("bp");
        check("nom_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Early last on beat 5, then a full all-0xFF vector
        send_vec(6, 0, 5, 1'b0);
        @(negedge clk);
        check("early_ferr", 32'(frame_err), 32'd1);
        check("early_rdy", 32'(s_ready), 32'd1);
        @(negedge clk);
        check("early_ferr_clr", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        send_vec(IN, 1, IN - 1, 1'b0);
        check_result("ones", Z_ONES, 1'b0);
        drain("ones");
        check("early_ferr_cnt", 32'(ferr_cnt), 32'd1);

        // Missing last: error pulse but normal delivery
        send_vec(IN, 0, -1, 1'b0);
        check_result("nolast", Z_RAMP, 1'b1);
        drain("nolast");
        check("nolast_ferr_cnt", 32'(ferr_cnt), 32'd2);

        // All-zero vector exercises the ReLU floor
        send_vec(IN, 2, IN - 1, 1'b0);
        check_result("zero", Z_ZERO, 1'b0);
        drain("zero");

        // Random gaps with garbage on s_data while s_valid is low
        send_vec(IN, 0, IN - 1, 1'b1);
        check_result("gaps", Z_RAMP, 1'b0);
        drain("gaps");

        // Reset mid-fill
        send_vec(40, 1, -1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_x_zero("midrst_xvec");
        check("midrst_vld", 32'(m_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rdy", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        send_vec(IN, 0, IN - 1, 1'b0);
        check_result("postrst", Z_RAMP, 1'b0);
        drain("postrst");

        // Reset during SETTLE: the aborted vector never produces m_valid
        send_vec(IN, 1, IN - 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (m_valid !== 1'b0) seen++;
            end
            check("abort_no_vld", 32'(seen), 32'd0);
        end
        check("abort_rdy", 32'(s_ready), 32'd1);
        check("final_ferr_cnt", 32'(ferr_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_act_loader.md
FC_ACT_LOADER -- requirements
Module: fc_act_loader

Interface
REQ-001 Parameter WIDTH, default 8, activation element width in bits.
REQ-002 Parameter IN, default 128, number of activations per vector.
REQ-003 Parameter SETTLE, default 2 (legal range >=1), clock cycles allowed for the combinational layer to settle before result capture.
REQ-004 Derived constant ZW = WIDTH*2+$clog2(IN), default 23, result width.
REQ-005 The block has one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous reset, active low.
REQ-008 s_data  input  WIDTH  activation byte stream.
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  loader accepts s_data.
REQ-011 s_last  input  1  marks the final element of a vector.
REQ-012 x_vec  output  IN x WIDTH (unpacked [0:IN-1])  activation vector driven to the layer x port.
REQ-013 z_in  input  ZW  layer ReLU result, combinational from x_vec.
REQ-014 m_data  output  ZW  registered result.
REQ-015 m_valid  output  1  m_data valid.
REQ-016 m_ready  input  1  downstream accepts m_data.
REQ-017 frame_err  output  1  one-cycle pulse on a framing mismatch.

Function
REQ-018 States: FILL, SETTLE, OUT; reset state is FILL.
REQ-019 FILL: s_ready=1; on s_valid&s_ready, write x_vec[idx]=s_data and increment idx; with s_valid low, idx and x_vec hold.
REQ-020 FILL, accepted beat with idx==IN-1: go to SETTLE, load cnt=SETTLE-1, reset idx to 0.
REQ-021 FILL, accepted beat with s_last=1 and idx<IN-1: pulse frame_err, reset idx to 0, stay in FILL; the partial vector is discarded (it is overwritten by the next vector).
REQ-022 FILL, accepted beat with idx==IN-1 and s_last=0: pulse frame_err and still proceed to SETTLE.
REQ-023 SETTLE: s_ready=0 and x_vec stays stable; if cnt==0, capture z_in into m_data, set m_valid=1, and go to OUT; otherwise decrement cnt.
REQ-024 Latency: if the last beat is accepted at edge N, m_valid rises at edge N+SETTLE.
REQ-025 OUT: s_ready=0; m_data and m_valid stay stable while m_ready=0.
REQ-026 OUT, m_valid&m_ready: clear m_valid and go to FILL; the next s_data beat can be accepted from the following cycle.
REQ-027 m_data is not sign-extended or requantized; z_in is captured bit-exact at ZW bits.
REQ-028 frame_err is high for exactly one cycle per mismatch, and is registered.
REQ-029 s_ready is a function of state only, with no combinational path from s_valid or m_ready.

Reset
REQ-030 While rst_n=0: state=FILL, idx=0, cnt=0, all x_vec elements 0, m_data=0, m_valid=0, frame_err=0, and s_ready=1 once rst_n=1.
REQ-031 Reset asserted in any state aborts the operation immediately; no m_valid is produced for the aborted vector.

Structure
REQ-032 Shared package fc_pkg holds the WIDTH, IN and ZW defaults and the state enum type (FILL, SETTLE, OUT).
REQ-033 The block has no sub-module; the layer instance lives in the parent, with x_vec wired to x and z wired to z_in.

Verification
REQ-034 Reset mid-fill: 40 beats sent, then rst_n low for 1 cycle -> x_vec all 0, m_valid=0, s_ready=1; a fresh 128-beat vector completes normally.
REQ-035 Nominal: x[i]=i for i=0..127 (with WIDTH=8, values wrap modulo 256), s_last on beat 127, reference model of the layer -> m_data equals the model result exactly SETTLE=2 edges after the last beat; frame_err never asserts.
REQ-036 Backpressure: m_ready=0 for 10 cycles after m_valid rises -> m_data and m_valid stay stable and s_ready=0; with m_ready=1 -> m_valid drops next edge and s_ready=1.
REQ-037 Early last: s_last on beat index 5 -> one frame_err pulse; the next 128 beats (values 0xFF) produce the result for the all-0xFF vector.
REQ-038 Missing last: 128 beats with s_last=0 -> frame_err pulse on beat 127, and the result is still delivered with nominal latency.
REQ-039 Gaps: s_valid deasserted randomly (50%) during fill -> idx holds during gaps, and the result matches the gap-free run.
